// File: rtl/fpdiv.sv
// rtl/fpdiv.sv - sequential IEEE-754 single-precision divider, restoring mantissa divide, one quotient bit per cycle
module fpdiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] P,
  output logic        Done,
  output logic        OF,
  output logic        UF,
  output logic        DZ,
  output logic        NV
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DIV, S_NORM, S_ROUND, S_RANGE, S_PACK, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [31:0]        r_a, r_b;
  logic               r_sign;
  logic [24:0]        r_r;
  logic [23:0]        r_d;
  logic [25:0]        r_q;
  logic [4:0]         r_cnt;
  logic signed [9:0]  r_e;
  logic [23:0]        r_m;
  logic               r_g;
  logic               r_spec;
  logic [31:0]        r_spec_p;
  logic [31:0]        r_p;
  logic               r_of, r_uf, r_dz, r_nv;

  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic        w_sign;
  logic        w_za, w_zb, w_ia, w_ib, w_na, w_nb;
  logic        w_special;
  logic [31:0] w_spec_p;
  logic        w_set_nv, w_set_dz;
  logic [9:0]  w_e_init;
  logic        w_ge;
  logic [24:0] w_sub;
  logic [24:0] w_m_inc;

  assign w_ea   = r_a[30:23];
  assign w_eb   = r_b[30:23];
  assign w_fa   = r_a[22:0];
  assign w_fb   = r_b[22:0];
  assign w_sign = r_a[31] ^ r_b[31];
  assign w_za   = (w_ea == 8'd0);
  assign w_zb   = (w_eb == 8'd0);
  assign w_ia   = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_ib   = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_na   = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_nb   = (w_eb == 8'hFF) && (w_fb != 23'd0);

  assign w_e_init = {2'b00, w_ea} - {2'b00, w_eb} + 10'd127;
  assign w_ge     = (r_r >= {1'b0, r_d});
  assign w_sub    = r_r - {1'b0, r_d};
  assign w_m_inc  = {1'b0, r_m} + 25'd1;

  // Special-operand classification; priority: invalid, inf dividend, divide-by-zero, zero result.
  always_comb begin
    w_special = 1'b1;
    w_spec_p  = 32'd0;
    w_set_nv  = 1'b0;
    w_set_dz  = 1'b0;
    if (w_na || w_nb || (w_ia && w_ib) || (w_za && w_zb)) begin
      w_spec_p = 32'h7FC00000;
      w_set_nv = 1'b1;
    end else if (w_ia) begin
      w_spec_p = {w_sign, 8'hFF, 23'd0};
    end else if (w_zb) begin
      w_spec_p = {w_sign, 8'hFF, 23'd0};
      w_set_dz = 1'b1;
    end else if (w_za || w_ib) begin
      w_spec_p = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_next = S_CHECK;
      S_CHECK: w_next = w_special ? S_PACK : S_DIV;
      S_DIV:   if (r_cnt == 5'd25) w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_RANGE;
      S_RANGE: w_next = S_PACK;
      S_PACK:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= 32'd0; r_b <= 32'd0; r_sign <= 1'b0;
      r_r <= 25'd0; r_d <= 24'd0; r_q <= 26'd0; r_cnt <= 5'd0;
      r_e <= 10'sd0; r_m <= 24'd0; r_g <= 1'b0;
      r_spec <= 1'b0; r_spec_p <= 32'd0; r_p <= 32'd0;
      r_of <= 1'b0; r_uf <= 1'b0; r_dz <= 1'b0; r_nv <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (Start) begin
          r_a <= A; r_b <= B;
          r_of <= 1'b0; r_uf <= 1'b0; r_dz <= 1'b0; r_nv <= 1'b0;
          r_spec <= 1'b0;
        end
        S_CHECK: begin
          r_sign   <= w_sign;
          r_spec   <= w_special;
          r_spec_p <= w_spec_p;
          r_nv     <= w_set_nv;
          r_dz     <= w_set_dz;
          r_r      <= {2'b01, w_fa};
          r_d      <= {1'b1, w_fb};
          r_q      <= 26'd0;
          r_cnt    <= 5'd0;
          r_e      <= $signed(w_e_init);
        end
        S_DIV: begin
          r_r   <= w_ge ? {w_sub[23:0], 1'b0} : {r_r[23:0], 1'b0};
          r_q   <= {r_q[24:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        S_NORM: begin
          if (r_q[25]) begin
            r_m <= r_q[25:2]; r_g <= r_q[1];
          end else begin
            r_m <= r_q[24:1]; r_g <= r_q[0];
            r_e <= r_e - 10'sd1;
          end
        end
        S_ROUND: if (r_g) begin
          if (w_m_inc[24]) begin
            r_m <= 24'h800000;
            r_e <= r_e + 10'sd1;
          end else begin
            r_m <= w_m_inc[23:0];
          end
        end
        S_RANGE: begin
          if (r_e >= 10'sd255) begin
            r_of <= 1'b1; r_spec <= 1'b1; r_spec_p <= {r_sign, 8'hFF, 23'd0};
          end else if (r_e <= 10'sd0) begin
            r_uf <= 1'b1; r_spec <= 1'b1; r_spec_p <= {r_sign, 31'd0};
          end
        end
        S_PACK: r_p <= r_spec ? r_spec_p : {r_sign, r_e[7:0], r_m[22:0]};
        default: ;
      endcase
    end
  end

  assign P    = r_p;
  assign Done = (r_state == S_DONE);
  assign OF   = r_of;
  assign UF   = r_uf;
  assign DZ   = r_dz;
  assign NV   = r_nv;

endmodule

// File: tb/tb_fpdiv.sv
// tb/tb_fpdiv.sv - directed scoreboard bench for fpdiv
module tb_fpdiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] P;
  logic        Done, OF, UF, DZ, NV;

  fpdiv dut (
    .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B),
    .P(P), .Done(Done), .OF(OF), .UF(UF), .DZ(DZ), .NV(NV)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] p;
    logic [3:0]  fl;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flags are compared as {OF,UF,DZ,NV}. glitch_at >= 0 pulses a stray Start at that cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [3:0] fl, input int lat,
                        input int glitch_at);
    exp_t e;
    int   cyc;
    e.p = p; e.fl = fl; e.lat = lat[7:0];
    sb.push_back(e);
    @(negedge clk);
    A = a; B = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    check({tag, "_flags_cleared"}, {28'd0, OF, UF, DZ, NV}, 32'd0);
    cyc = 0;
    while (!Done && cyc < 60) begin
      if (cyc == glitch_at) begin
        A = 32'h3F800000; B = 32'h40400000; Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    Start = 1'b0;
    e = sb.pop_front();
    check({tag, "_latency"}, cyc, {24'd0, e.lat});
    check({tag, "_P"}, P, e.p);
    check({tag, "_flags"}, {28'd0, OF, UF, DZ, NV}, {28'd0, e.fl});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, Done}, 32'd0);
    check({tag, "_hold_P"}, P, e.p);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_P", P, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_flags", {28'd0, OF, UF, DZ, NV}, 32'd0);

    run_op("div_6_2",     32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 31, -1);
    run_op("div_1_3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 31, -1);
    run_op("div_neg8_2",  32'hC1000000, 32'h40000000, 32'hC0800000, 4'b0000, 31, -1);
    run_op("div_1_1",     32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 31, -1);
    run_op("div_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0010, 2, -1);
    run_op("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 2, -1);
    run_op("inf_inf",     32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0001, 2, -1);
    run_op("nan_one",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0001, 2, -1);
    run_op("inf_two",     32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2, -1);
    run_op("two_inf",     32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 2, -1);
    run_op("subn_one",    32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 2, -1);
    run_op("overflow",    32'h7F000000, 32'h00800000, 32'h7F800000, 4'b1000, 31, -1);
    run_op("underflow",   32'h00800000, 32'h7F000000, 32'h00000000, 4'b0100, 31, -1);
    run_op("e_255",       32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b1000, 31, -1);
    run_op("e_254",       32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 31, -1);
    run_op("e_1",         32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 31, -1);
    run_op("e_0",         32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 31, -1);
    run_op("start_ignored", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 31, 9);

    // Abort mid-division: no Done, P and flags cleared.
    @(negedge clk);
    A = 32'h3F800000; B = 32'h40400000; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      rst = (c == 14);
      @(posedge clk); #1;
      if (Done) seen++;
    end
    rst = 1'b0;
    check("abort_no_done", seen, 0);
    check("abort_P", P, 32'd0);
    check("abort_flags", {28'd0, OF, UF, DZ, NV}, 32'd0);

    run_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 31, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
